// File: rtl/aes_dec_pipe_ctrl.sv
// Valid/ready flow controller around a free-running AES-128 decrypt pipeline:
// slot tracking, credit-limited output FIFO, key10 ownership. Optional perf counters: AES_DEC_PERF_EN.
module aes_dec_pipe_ctrl #(
  parameter int PIPE_LAT   = 20,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_wr_valid,
  input  logic [127:0] key_wr_data,
  output logic         key_wr_ready,
  input  logic         s_valid,
  input  logic [127:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [127:0] m_data,
  input  logic         m_ready,
  output logic [127:0] dp_ciphertext,
  output logic [127:0] dp_key10,
  input  logic [127:0] dp_plaintext,
`ifdef AES_DEC_PERF_EN
  output logic [31:0]  perf_in_cnt,
  output logic [31:0]  perf_out_cnt,
  output logic [31:0]  perf_stall_cnt,
`endif
  output logic         busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {NOKEY, RUN, DRAIN, LOAD} state_e;

  state_e              state_q;
  logic [127:0]        key_q;
  logic                key_rdy_q;
  logic [PIPE_LAT-1:0] vsr_q, vsr_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [127:0]        mem_q [FIFO_DEPTH];
  logic [CNT_W:0]      credit_used;
  logic                issue, done, pop, empty;

  assign empty         = (cnt_q == '0);
  assign credit_used   = {1'b0, inflight_q} + {1'b0, cnt_q};
  // A pending key request blocks admission so the drain starts cleanly.
  assign s_ready       = (state_q == RUN) && !key_wr_valid &&
                         (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign issue         = s_valid && s_ready;
  assign done          = vsr_q[PIPE_LAT-1];
  assign pop           = m_valid && m_ready;
  assign m_valid       = !empty;
  assign m_data        = empty ? '0 : mem_q[rptr_q];
  assign dp_ciphertext = s_data;
  assign dp_key10      = key_q;
  assign key_wr_ready  = key_rdy_q;
  assign busy          = (inflight_q != '0) || !empty;

  always_comb begin
    vsr_d      = {vsr_q[PIPE_LAT-2:0], issue};
    inflight_d = inflight_q;
    cnt_d      = cnt_q;
    case ({issue, done})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({done, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= NOKEY;
      key_q     <= '0;
      key_rdy_q <= 1'b0;
    end else begin
      key_rdy_q <= 1'b0;
      case (state_q)
        NOKEY: if (key_wr_valid) begin
          state_q   <= LOAD;
          key_rdy_q <= 1'b1;
        end
        RUN:   if (key_wr_valid) state_q <= DRAIN;
        // FIFO contents were computed with the old key, so only the pipe must empty.
        DRAIN: if (inflight_q == '0) begin
          state_q   <= LOAD;
          key_rdy_q <= 1'b1;
        end
        LOAD: begin
          key_q   <= key_wr_data;
          state_q <= RUN;
        end
        default: state_q <= NOKEY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsr_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      vsr_q      <= vsr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      if (done) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (done) mem_q[wptr_q] <= dp_plaintext;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(done && (cnt_q == CNT_W'(FIFO_DEPTH))));

`ifdef AES_DEC_PERF_EN
  logic [31:0] perf_in_q, perf_out_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_in_q    <= '0;
      perf_out_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (issue && perf_in_q != '1)                  perf_in_q    <= perf_in_q + 32'd1;
      if (pop && perf_out_q != '1)                   perf_out_q   <= perf_out_q + 32'd1;
      if (s_valid && !s_ready && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_in_cnt    = perf_in_q;
  assign perf_out_cnt   = perf_out_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_aes_dec_pipe_ctrl.sv
// Self-checking bench for aes_dec_pipe_ctrl; a stand-in 20-cycle datapath replaces the AES core.
module tb_aes_dec_pipe_ctrl;
  localparam int LAT = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_wr_valid = 1'b0;
  logic [127:0] key_wr_data = '0;
  logic         key_wr_ready;
  logic         s_valid = 1'b0;
  logic [127:0] s_data = '0;
  logic         s_ready;
  logic         m_valid;
  logic [127:0] m_data;
  logic         m_ready = 1'b0;
  logic [127:0] dp_ciphertext, dp_key10, dp_plaintext;
  logic         busy;

  aes_dec_pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .key_wr_valid(key_wr_valid), .key_wr_data(key_wr_data), .key_wr_ready(key_wr_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .dp_ciphertext(dp_ciphertext), .dp_key10(dp_key10), .dp_plaintext(dp_plaintext),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in decrypt transform, used both by the mock datapath and the expectation queue.
  function automatic logic [127:0] dec_fn(input logic [127:0] ct, input logic [127:0] k);
    return {ct[63:0], ct[127:64]} ^ k ^ 128'h5a5a_c3c3_0ff0_1234_a5a5_3c3c_f00f_4321;
  endfunction

  logic [127:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= dec_fn(dp_ciphertext, dp_key10);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_plaintext = pipe[LAT-1];

  int           tests = 0, fails = 0;
  logic [127:0] cur_key = '0;
  logic [127:0] exp_q [$];
  logic [127:0] exp_v;
  logic         sfire, mfire, smp_sready, smp_mvalid, smp_busy, smp_kready;
  logic [127:0] smp_mdata;
  int           cyc_n = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: sample at negedge, book accepted blocks, return just after posedge.
  task automatic cyc();
    @(negedge clk);
    smp_sready = s_ready;
    smp_mvalid = m_valid;
    smp_busy   = busy;
    smp_kready = key_wr_ready;
    smp_mdata  = m_data;
    sfire      = s_valid && s_ready;
    mfire      = m_valid && m_ready;
    if (sfire) exp_q.push_back(dec_fn(s_data, cur_key));
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    tests++;
    if (smp_sready !== 1'b0 || smp_mvalid !== 1'b0 || smp_busy !== 1'b0 ||
        smp_kready !== 1'b0 || smp_mdata !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got s_ready=%b m_valid=%b busy=%b kready=%b m_data=%0h, required all 0",
               smp_sready, smp_mvalid, smp_busy, smp_kready, smp_mdata);
    end
    s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_data = rnd128();
      cyc();
      tests++;
      if (smp_sready !== 1'b0 || smp_mvalid !== 1'b0 || smp_busy !== 1'b0) begin
        fails++;
        $display("FAIL nokey_idle: cycle %0d got s_ready=%b m_valid=%b busy=%b, required 0",
                 i, smp_sready, smp_mvalid, smp_busy);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_key_load(input logic [127:0] k);
    int pulses = 0, at = -1;
    key_wr_data  = k;
    key_wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (smp_kready) begin
        pulses++;
        at = i;
        key_wr_valid = 1'b0;
        cur_key = k;
      end
    end
    tests++;
    if (pulses != 1 || at != 1) begin
      fails++;
      $display("FAIL key_load_pulse: got %0d pulses at cycle %0d, required 1 pulse at cycle 1", pulses, at);
    end
    tests++;
    if (dp_key10 !== k) begin
      fails++;
      $display("FAIL key_load_value: got %0h required %0h", dp_key10, k);
    end
  endtask

  task automatic test_latency();
    int n = 0;
    logic found = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = rnd128();
    cyc();
    s_valid = 1'b0;
    tests++;
    if (!sfire) begin
      fails++;
      $display("FAIL single_issue: got s_ready=%b required 1", smp_sready);
    end
    while (!found && n < 40) begin
      cyc();
      n++;
      if (smp_mvalid) begin
        found = 1'b1;
        exp_v = exp_q.pop_front();
        tests++;
        if (smp_mdata !== exp_v) begin
          fails++;
          $display("FAIL single_data: got %0h required %0h", smp_mdata, exp_v);
        end
      end
    end
    tests++;
    if (!found || n != LAT + 1) begin
      fails++;
      $display("FAIL single_latency: got m_valid after %0d cycles (found=%b), required %0d", n, found, LAT + 1);
    end
  endtask

  task automatic test_fill();
    int acc = 0, pops = 0, n = 0;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      s_data = rnd128();
      cyc();
      if (sfire) acc++;
      if (smp_mvalid) begin
        tests++;
        if (smp_mdata !== exp_q[0]) begin
          fails++;
          $display("FAIL fill_head_hold: cycle %0d got %0h required %0h", i, smp_mdata, exp_q[0]);
        end
      end
    end
    s_valid = 1'b0;
    tests++;
    if (acc != 32 || smp_sready !== 1'b0) begin
      fails++;
      $display("FAIL fill_credit: got %0d accepted s_ready=%b, required 32 accepted s_ready=0", acc, smp_sready);
    end
    m_ready = 1'b1;
    while (pops < 32 && n < 60) begin
      cyc();
      n++;
      if (mfire) begin
        pops++;
        exp_v = exp_q.pop_front();
        tests++;
        if (smp_mdata !== exp_v) begin
          fails++;
          $display("FAIL fill_drain_order: pop %0d got %0h required %0h", pops, smp_mdata, exp_v);
        end
      end
    end
    tests++;
    if (pops != 32) begin
      fails++;
      $display("FAIL fill_drain_count: got %0d pops required 32", pops);
    end
  endtask

  task automatic test_back_to_back();
    int outs = 0, first = -1, last = -1, n = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 100 + LAT + 20 && outs < 100; i++) begin
      s_valid = (i < 100);
      s_data  = rnd128();
      cyc();
      if (i < 100) begin
        tests++;
        if (!sfire) begin
          fails++;
          $display("FAIL b2b_s_ready: cycle %0d got s_ready=%b required 1", i, smp_sready);
        end
      end
      if (mfire) begin
        outs++;
        if (first < 0) first = cyc_n;
        last = cyc_n;
        exp_v = exp_q.pop_front();
        tests++;
        if (smp_mdata !== exp_v) begin
          fails++;
          $display("FAIL b2b_order: out %0d got %0h required %0h", outs, smp_mdata, exp_v);
        end
      end
      n = i;
    end
    s_valid = 1'b0;
    tests++;
    if (outs != 100 || last - first != 99) begin
      fails++;
      $display("FAIL b2b_throughput: got %0d outputs over %0d cycles (ran %0d), required 100 over 100",
               outs, last - first + 1, n);
    end
  endtask

  task automatic test_random();
    int n = 0;
    for (int i = 0; i < 300; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_data  = rnd128();
      cyc();
      if (mfire) begin
        exp_v = exp_q.pop_front();
        tests++;
        if (smp_mdata !== exp_v) begin
          fails++;
          $display("FAIL random_order: cycle %0d got %0h required %0h", i, smp_mdata, exp_v);
        end
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
      if (mfire) begin
        exp_v = exp_q.pop_front();
        tests++;
        if (smp_mdata !== exp_v) begin
          fails++;
          $display("FAIL random_drain: got %0h required %0h", smp_mdata, exp_v);
        end
      end
    end
    cyc();
    tests++;
    if (exp_q.size() != 0 || smp_busy !== 1'b0 || smp_mvalid !== 1'b0) begin
      fails++;
      $display("FAIL random_idle: got %0d outstanding busy=%b m_valid=%b, required 0 0 0",
               exp_q.size(), smp_busy, smp_mvalid);
    end
  endtask

  task automatic test_key_change(input logic [127:0] k2);
    int pops = 0, n = 0;
    logic got = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = rnd128();
      cyc();
      tests++;
      if (!sfire) begin
        fails++;
        $display("FAIL keychg_issue: block %0d got s_ready=%b required 1", i, smp_sready);
      end
    end
    key_wr_valid = 1'b1;
    key_wr_data  = k2;
    while (!got && n < 60) begin
      s_data = rnd128();
      cyc();
      n++;
      tests++;
      if (smp_sready !== 1'b0) begin
        fails++;
        $display("FAIL keychg_stall: cycle %0d got s_ready=%b required 0", n, smp_sready);
      end
      if (mfire) begin
        pops++;
        exp_v = exp_q.pop_front();
        tests++;
        if (smp_mdata !== exp_v) begin
          fails++;
          $display("FAIL keychg_old_data: got %0h required %0h", smp_mdata, exp_v);
        end
      end
      if (smp_kready) begin
        got = 1'b1;
        key_wr_valid = 1'b0;
        cur_key = k2;
      end
    end
    tests++;
    if (!got || pops != 10) begin
      fails++;
      $display("FAIL keychg_drain: got kready=%b after %0d retired, required 1 after 10", got, pops);
    end
    cyc();
    s_valid = 1'b0;
    tests++;
    if (!sfire) begin
      fails++;
      $display("FAIL keychg_resume: got s_ready=%b required 1", smp_sready);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cyc();
      n++;
      if (mfire) begin
        exp_v = exp_q.pop_front();
        tests++;
        if (smp_mdata !== exp_v) begin
          fails++;
          $display("FAIL keychg_new_data: got %0h required %0h", smp_mdata, exp_v);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL keychg_timeout: got %0d outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin s_data = rnd128(); cyc(); end
    s_valid = 1'b0;
    repeat (22) cyc();
    s_valid = 1'b1;
    repeat (5) begin s_data = rnd128(); cyc(); end
    s_valid = 1'b0;
    repeat (2) cyc();
    tests++;
    if (smp_mvalid !== 1'b1 || exp_q.size() != 8) begin
      fails++;
      $display("FAIL rstmid_setup: got m_valid=%b queued=%0d, required 1 and 8", smp_mvalid, exp_q.size());
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    cur_key = '0;
    cyc();
    tests++;
    if (smp_mvalid !== 1'b0 || smp_busy !== 1'b0 || dp_key10 !== '0) begin
      fails++;
      $display("FAIL rstmid_clear: got m_valid=%b busy=%b key=%0h, required 0 0 0", smp_mvalid, smp_busy, dp_key10);
    end
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_data = rnd128();
      cyc();
      tests++;
      if (smp_mvalid !== 1'b0 || smp_sready !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_quiet: cycle %0d got m_valid=%b s_ready=%b, required 0 0", i, smp_mvalid, smp_sready);
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_key_load(128'h13111d7fe3944a17f307a78b4d2b30c5);
    test_latency();
    test_fill();
    test_back_to_back();
    test_random();
    test_key_change(rnd128());
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
